// File: rtl/menu_input_pkg.sv
// Shared key codes and repeat-state encoding for the battle menu input path.
// The menu stage imports the same key codes so both ends agree on their meaning.
package menu_input_pkg;

    localparam logic [1:0] KEY_NONE  = 2'b00;
    localparam logic [1:0] KEY_RIGHT = 2'b01;
    localparam logic [1:0] KEY_LEFT  = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        HOLD_DELAY,
        GAP,
        HOLD_RATE
    } repeat_state_t;

    // A lone left or right press gives its code. Both held, or neither held,
    // gives no key, so the menu never sees the unused code 11.
    function automatic logic [1:0] encode_keys(input logic left, input logic right);
        logic [1:0] code;
        unique case ({left, right})
            2'b10:   code = KEY_LEFT;
            2'b01:   code = KEY_RIGHT;
            default: code = KEY_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// One raw button: a two-flop synchroniser followed by a stability-count debouncer.
// A new level is accepted only after the synchronised input has disagreed with
// the accepted level for DEBOUNCE_CYCLES consecutive cycles.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 650000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          meta;
    logic          sync;
    logic          stable;
    logic [CW-1:0] count;

    // Bring the asynchronous pin into the clk domain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= raw;
            sync <= meta;
        end
    end

    // Count consecutive disagreeing cycles; any agreement restarts the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stable <= 1'b0;
            count  <= '0;
        end else if (sync == stable) begin
            count <= '0;
        end else if (count == LAST) begin
            stable <= sync;
            count  <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign level = stable;

endmodule

// File: rtl/menu_input_conditioner.sv
// Conditions the left, right and decide buttons for the battle menu.
// Left/right become a registered 2-bit key code; decide becomes a registered
// level plus a one-cycle press pulse.
// Optional feature: define KEY_REPEAT_EN to add hold-to-repeat on the key code.
// Each repeat is announced by a short forced 00 gap so that the menu's edge
// detector re-arms.
module menu_input_conditioner
    import menu_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES     = 650000,
    parameter int REPEAT_DELAY_CYCLES = 32500000,
    parameter int REPEAT_RATE_CYCLES  = 9750000,
    parameter int REPEAT_GAP_CYCLES   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_left_in,
    input  logic       btn_right_in,
    input  logic       btn_decide_in,
    output logic [1:0] key_input_out,
    output logic       decide_out,
    output logic       decide_pulse_out
);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY_CYCLES < 1 || REPEAT_GAP_CYCLES < 1 ||
        REPEAT_RATE_CYCLES <= REPEAT_GAP_CYCLES) begin : g_bad_params
        $error("menu_input_conditioner: illegal parameter combination");
    end

    logic       left_level;
    logic       right_level;
    logic       decide_level;
    logic [1:0] code;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_left_in),
        .level (left_level)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_right_in),
        .level (right_level)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_decide (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_decide_in),
        .level (decide_level)
    );

    assign code = encode_keys(left_level, right_level);

    // Register the decide level; the pulse fires when the level is about to rise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            decide_out       <= 1'b0;
            decide_pulse_out <= 1'b0;
        end else begin
            decide_pulse_out <= decide_level & ~decide_out;
            decide_out       <= decide_level;
        end
    end

`ifdef KEY_REPEAT_EN

    localparam int LONGEST = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                             REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
    localparam int RW = (LONGEST > 2) ? $clog2(LONGEST) : 1;
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE_CYCLES - 1);
    localparam logic [RW-1:0] GAP_LAST   = RW'(REPEAT_GAP_CYCLES - 1);

    repeat_state_t state, state_next;
    logic [RW-1:0] count, count_next;
    logic [1:0]    held, held_next;
    logic [1:0]    key, key_next;

    // Repeat FSM registers; key is the registered key output itself.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            count <= '0;
            held  <= KEY_NONE;
            key   <= KEY_NONE;
        end else begin
            state <= state_next;
            count <= count_next;
            held  <= held_next;
            key   <= key_next;
        end
    end

    // The counter restarts on entering HOLD_DELAY or GAP and keeps running through
    // the gap, so the repeat period counts from the start of one gap to the next.
    always_comb begin
        state_next = state;
        count_next = count;
        held_next  = held;
        key_next   = key;
        if (code == KEY_NONE) begin
            state_next = IDLE;
            count_next = '0;
            held_next  = KEY_NONE;
            key_next   = KEY_NONE;
        end else if (state == IDLE || code != held) begin
            state_next = HOLD_DELAY;
            count_next = '0;
            held_next  = code;
            key_next   = code;
        end else begin
            unique case (state)
                HOLD_DELAY: begin
                    if (count == DELAY_LAST) begin
                        state_next = GAP;
                        count_next = '0;
                        key_next   = KEY_NONE;
                    end else begin
                        count_next = count + RW'(1);
                        key_next   = held;
                    end
                end
                GAP: begin
                    count_next = count + RW'(1);
                    if (count == GAP_LAST) begin
                        state_next = HOLD_RATE;
                        key_next   = held;
                    end else begin
                        key_next = KEY_NONE;
                    end
                end
                HOLD_RATE: begin
                    if (count == RATE_LAST) begin
                        state_next = GAP;
                        count_next = '0;
                        key_next   = KEY_NONE;
                    end else begin
                        count_next = count + RW'(1);
                        key_next   = held;
                    end
                end
                default: begin
                    state_next = IDLE;
                    count_next = '0;
                    held_next  = KEY_NONE;
                    key_next   = KEY_NONE;
                end
            endcase
        end
    end

    assign key_input_out = key;

`else

    logic [1:0] key;

    // Without repeat the key output is simply the registered code.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key <= KEY_NONE;
        end else begin
            key <= code;
        end
    end

    assign key_input_out = key;

`endif

endmodule

// File: tb/tb_menu_input_conditioner.sv
// Self-checking bench for menu_input_conditioner: reset, truth table, bounce,
// simultaneous press, decide pulse, auto-repeat (when KEY_REPEAT_EN is defined)
// and a randomized run checked every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_menu_input_conditioner;

    localparam int DB    = 4;
    localparam int DELAY = 20;
    localparam int RATE  = 10;
    localparam int GAPC  = 2;
`ifdef KEY_REPEAT_EN
    localparam bit REPEAT_ON = 1'b1;
`else
    localparam bit REPEAT_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic       btn_decide = 1'b0;
    logic [1:0] key;
    logic       decide;
    logic       pulse;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    menu_input_conditioner #(
        .DEBOUNCE_CYCLES     (DB),
        .REPEAT_DELAY_CYCLES (DELAY),
        .REPEAT_RATE_CYCLES  (RATE),
        .REPEAT_GAP_CYCLES   (GAPC)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .btn_left_in      (btn_left),
        .btn_right_in     (btn_right),
        .btn_decide_in    (btn_decide),
        .key_input_out    (key),
        .decide_out       (decide),
        .decide_pulse_out (pulse)
    );

    // Behavioural model: raw samples history, accepted levels, repeat timer.
    logic [15:0] hist_l, hist_r, hist_d;
    logic        m_left, m_right, m_decide, m_dec_out, m_pulse;
    logic [1:0]  m_key, m_held;
    int          m_t;
    bit          model_on = 1'b0;

    typedef struct {
        logic       l;
        logic       r;
        logic       d;
        logic [1:0] key;
        logic       dec;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [1:0] code_of(input logic l, input logic r);
        if (l && !r) return 2'b10;
        if (r && !l) return 2'b01;
        return 2'b00;
    endfunction

    // A level flips once the last DB synchronised samples all oppose it.
    function automatic logic settle(input logic [15:0] h, input logic s);
        logic [DB-1:0] w;
        w = h[DB+1:2];
        if (w == {DB{~s}}) return ~s;
        return s;
    endfunction

    task automatic model_clear();
        hist_l = '0; hist_r = '0; hist_d = '0;
        m_left = 0; m_right = 0; m_decide = 0; m_dec_out = 0; m_pulse = 0;
        m_key = 2'b00; m_held = 2'b00; m_t = 0;
    endtask

    task automatic model_update();
        logic [1:0] c;
        hist_l = {hist_l[14:0], btn_left};
        hist_r = {hist_r[14:0], btn_right};
        hist_d = {hist_d[14:0], btn_decide};
        c = code_of(m_left, m_right);
        if (c == 2'b00) begin
            m_held = 2'b00; m_t = 0; m_key = 2'b00;
        end else if (c != m_held) begin
            m_held = c; m_t = 0; m_key = c;
        end else begin
            m_t++;
            if (REPEAT_ON && m_t >= DELAY && ((m_t - DELAY) % RATE) < GAPC) m_key = 2'b00;
            else m_key = c;
        end
        m_pulse   = m_decide & ~m_dec_out;
        m_dec_out = m_decide;
        m_left    = settle(hist_l, m_left);
        m_right   = settle(hist_r, m_right);
        m_decide  = settle(hist_d, m_decide);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic l, input logic r, input logic d);
        btn_left   = l;
        btn_right  = r;
        btn_decide = d;
    endtask

    // One clock: model follows the rising edge, outputs are compared at the falling edge.
    task automatic step();
        @(posedge clk);
        if (!rst) model_clear();
        else model_update();
        @(negedge clk);
        if (model_on) begin
            checkOutput("model_key", 32'(key), 32'(m_key));
            checkOutput("model_decide", 32'(decide), 32'(m_dec_out));
            checkOutput("model_pulse", 32'(pulse), 32'(m_pulse));
        end
    endtask

    task automatic release_all();
        applyStimulus(0, 0, 0);
        repeat (12) step();
    endtask

    initial begin
        int first_ten, ten_count, gaps, first_gap, zero_start;
        int press_pulses, release_pulses, dec_high, aligned;
        bit seen_ten, in_zero, seen_dec;

        vecs[0] = '{0, 0, 0, 2'b00, 0};
        vecs[1] = '{1, 0, 0, 2'b10, 0};
        vecs[2] = '{0, 1, 0, 2'b01, 0};
        vecs[3] = '{1, 1, 0, 2'b00, 0};
        vecs[4] = '{0, 0, 1, 2'b00, 1};
        vecs[5] = '{1, 0, 1, 2'b10, 1};
        vecs[6] = '{0, 1, 1, 2'b01, 1};
        vecs[7] = '{1, 1, 1, 2'b00, 1};

        model_clear();
        applyStimulus(0, 0, 0);
        repeat (3) step();
        rst = 1'b1;
        model_on = 1'b1;
        checkOutput("reset_key", 32'(key), 0);
        checkOutput("reset_decide", 32'(decide), 0);
        checkOutput("reset_pulse", 32'(pulse), 0);

        $display("[TB] truth table");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].l, vecs[i].r, vecs[i].d);
            repeat (10) step();
            checkOutput($sformatf("table_key[%0d]", i), 32'(key), 32'(vecs[i].key));
            checkOutput($sformatf("table_decide[%0d]", i), 32'(decide), 32'(vecs[i].dec));
            checkOutput($sformatf("table_pulse[%0d]", i), 32'(pulse), 0);
            release_all();
            checkOutput($sformatf("table_release_key[%0d]", i), 32'(key), 0);
        end

        $display("[TB] reset during press");
        applyStimulus(0, 1, 0);
        repeat (20) step();
        checkOutput("pre_reset_key", 32'(key), 1);
        rst = 1'b0;
        model_clear();
        #1;
        checkOutput("async_reset_key", 32'(key), 0);
        step();
        rst = 1'b1;
        for (int j = 1; j <= 7; j++) begin
            step();
            checkOutput($sformatf("reset_release_key[%0d]", j), 32'(key), (j < 7) ? 0 : 1);
        end

        $display("[TB] bounce");
        release_all();
        for (int k = 0; k < 6; k++) begin
            applyStimulus(0, 1, 0);
            repeat (3) begin step(); checkOutput("bounce_high_key", 32'(key), 0); end
            applyStimulus(0, 0, 0);
            step();
            checkOutput("bounce_low_key", 32'(key), 0);
        end
        applyStimulus(0, 1, 0);
        for (int j = 1; j <= 7; j++) begin
            step();
            checkOutput($sformatf("bounce_settle_key[%0d]", j), 32'(key), (j < 7) ? 0 : 1);
        end

        $display("[TB] simultaneous");
        release_all();
        applyStimulus(1, 1, 0);
        repeat (20) begin step(); checkOutput("both_key", 32'(key), 0); end
        applyStimulus(0, 1, 0);
        for (int j = 1; j <= 7; j++) begin
            step();
            checkOutput($sformatf("left_release_key[%0d]", j), 32'(key), (j < 7) ? 0 : 1);
        end

        $display("[TB] decide");
        release_all();
        press_pulses = 0; release_pulses = 0; dec_high = 0; aligned = 0; seen_dec = 0;
        applyStimulus(0, 0, 1);
        for (int s = 0; s < 30; s++) begin
            step();
            if (pulse) press_pulses++;
            if (decide) dec_high++;
            if (decide && !seen_dec && pulse) aligned = 1;
            if (decide) seen_dec = 1;
        end
        applyStimulus(0, 0, 0);
        for (int s = 0; s < 20; s++) begin
            step();
            if (pulse) release_pulses++;
            if (decide) dec_high++;
        end
        checkOutput("decide_press_pulses", press_pulses, 1);
        checkOutput("decide_release_pulses", release_pulses, 0);
        checkOutput("decide_high_cycles", dec_high, 30);
        checkOutput("decide_pulse_aligned", aligned, 1);

        $display("[TB] hold left");
        release_all();
        first_ten = 0; ten_count = 0; gaps = 0; first_gap = 0; zero_start = 0;
        seen_ten = 0; in_zero = 0;
        applyStimulus(1, 0, 0);
        for (int s = 1; s <= 80; s++) begin
            if (s == 61) applyStimulus(0, 0, 0);
            step();
            if (key == 2'b10) begin
                ten_count++;
                if (!seen_ten) first_ten = s;
                if (in_zero) begin
                    gaps++;
                    if (first_gap == 0) first_gap = zero_start;
                end
                seen_ten = 1;
                in_zero  = 0;
            end else if (seen_ten && !in_zero) begin
                in_zero    = 1;
                zero_start = s;
            end
        end
        checkOutput("hold_first_key_step", first_ten, 7);
        checkOutput("hold_key_cycles", ten_count, REPEAT_ON ? 52 : 60);
        checkOutput("hold_gap_count", gaps, REPEAT_ON ? 4 : 0);
        checkOutput("hold_first_gap_step", first_gap, REPEAT_ON ? 27 : 0);
        checkOutput("hold_final_key", 32'(key), 0);

        $display("[TB] random");
        for (int seg = 0; seg < 60; seg++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if (seg == 30) begin
                rst = 1'b0;
                model_clear();
                #1;
                step();
                rst = 1'b1;
            end
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(20, 45)) step();
            else repeat ($urandom_range(1, 8)) step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/menu_input_conditioner.md
# menu_input_conditioner

Conditions the three raw player buttons (left, right, decide) for the battle menu. Each button is synchronised and debounced. Left/right are encoded into the 2-bit key code the menu consumes, and decide is delivered as a clean level plus a one-cycle press pulse. The block sits between the board button pins and the menu stage. It guarantees the menu sees exactly one 00→nonzero transition per physical press, plus repeat transitions when the repeat feature is compiled in.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 650000: consecutive stable cycles required before a button state change is accepted (10 ms at 65 MHz); ≥2.
- REPEAT_DELAY_CYCLES, 32500000: hold time before the first auto-repeat (0.5 s).
- REPEAT_RATE_CYCLES, 9750000: period between subsequent auto-repeats; must exceed REPEAT_GAP_CYCLES.
- REPEAT_GAP_CYCLES, 2: length of the forced 00 gap that re-arms the menu's edge detector; ≥1.

Ports:
- clk  in  1  system clock (65 MHz pixel clock domain).
- rst  in  1  asynchronous, active-low reset.
- btn_left_in  in  1  raw left button, asynchronous, active-high.
- btn_right_in  in  1  raw right button, asynchronous, active-high.
- btn_decide_in  in  1  raw decide button, asynchronous, active-high.
- key_input_out  out  2  key code: 00 none, 01 right, 10 left; 11 never driven.
- decide_out  out  1  debounced decide level.
- decide_pulse_out  out  1  one-cycle pulse on each debounced decide rising edge.

## Operation
- Per button: a 2-FF synchroniser, then a debouncer holding `stable` and a counter sized with $clog2(DEBOUNCE_CYCLES).
  - While sync == stable, the counter is held at 0.
  - While sync != stable, the counter increments.
  - When the counter equals DEBOUNCE_CYCLES-1 and sync still differs, stable <= sync and the counter returns to 0.
  - Any single-cycle return to agreement clears the counter, so glitches shorter than DEBOUNCE_CYCLES never propagate.
- Encoding (combinational from the debounced levels; the result is `code`):
  - left only → 10.
  - right only → 01.
  - both or neither → 00.
  - Releasing one of two held buttons produces the other's code. This counts as a new press.
- key_input_out is registered from `code`; with the repeat feature compiled in, it also passes through the repeat FSM.
- decide_out is the registered debounced decide level.
- decide_pulse_out is high for exactly one cycle when debounced decide goes 0→1. There is no pulse on release.
- Reset: all synchroniser flops, stable levels and counters are cleared; key_input_out=00, decide_out=0, decide_pulse_out=0.
  - Asserting reset mid-press or mid-debounce discards all progress.
  - A button still held at reset release needs a full DEBOUNCE_CYCLES to be recognised.

## Timing
- Latency from the first raw-high sample to the output change: 2 (sync) + DEBOUNCE_CYCLES + 1 (output register) clk edges. Release latency is identical.
- decide_pulse_out asserts in the same cycle decide_out first reads 1.
- Outputs change only on clk rising edges and never glitch.

## Configuration
- KEY_REPEAT_EN defined: a repeat FSM sits on `code`, with one cycle counter sized for max(REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES).
  - States:
    - IDLE: output 00. If code != 00, go to HOLD_DELAY, output code, counter=0.
    - HOLD_DELAY: when the counter reaches REPEAT_DELAY_CYCLES-1, go to GAP.
    - GAP: output 00 for REPEAT_GAP_CYCLES, then go to HOLD_RATE and output code.
    - HOLD_RATE: when the counter reaches REPEAT_RATE_CYCLES-1, go to GAP.
  - From any state, code == 00 goes to IDLE.
  - From any state, a change of a nonzero code restarts in HOLD_DELAY with the new code.
  - Repeat never applies to decide.
- KEY_REPEAT_EN undefined: key_input_out = registered code. No repeat counter or FSM is synthesised, and the REPEAT_* parameters are ignored.

## Structure
- Package menu_input_pkg:
  - localparams KEY_NONE=2'b00, KEY_RIGHT=2'b01, KEY_LEFT=2'b10.
  - typedef enum repeat_state_t {IDLE, HOLD_DELAY, GAP, HOLD_RATE}.
  - The menu stage imports the same key codes.
- Sub-module button_debouncer (synchroniser + debounce, parameter DEBOUNCE_CYCLES), instantiated three times.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=20, REPEAT_RATE_CYCLES=10, REPEAT_GAP_CYCLES=2.
- Reset: hold right 20 cycles, drop rst low for one cycle → key_input_out=00 immediately. Re-asserted 01 appears exactly 7 edges after reset release.
- Bounce: right toggles high 3 / low 1 repeatedly → key_input_out stays 00. Right held steady → 01 on the 7th edge after the last rising raw edge.
- Simultaneous: left+right held → 00 throughout. Release left → 01 appears 7 edges after the release.
- Decide: press 30 cycles → decide_pulse_out high exactly 1 cycle, decide_out high ~30 cycles. Release → no pulse.
- KEY_REPEAT_EN: hold left 60 cycles → 10, then 00 for 2 cycles starting 20 cycles after the first 10, then a gap every 10 cycles. Exactly 4 gaps are seen.
- KEY_REPEAT_EN undefined, same stimulus → 10 continuously, zero gaps.
